// File: rtl/pipe_adder.sv
// Pipelined add/sub: one CW-bit ripple chunk per stage; latency STAGES cycles, 1 result/cycle.
// Global stall: every stage holds while out_valid && !out_ready, and in_ready follows that enable.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = WIDTH / STAGES;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // Subtract is folded in once at the input: a + ~b + ~ci.
    assign b_eff = sub ? ~b : b;
    assign c_eff = ci ^ sub;

    // Intermediate ranks 0..STAGES-2: each holds finished low chunks plus the
    // operand bits still to be added, skewed along with the transaction.
    for (genvar k = 0; k < STAGES - 1; k++) begin : stg
        localparam int RW = WIDTH - k * CW;
        localparam int DW = (k + 1) * CW;

        logic [RW-1:0]    pa;
        logic [RW-1:0]    pb;
        logic             pc;
        logic             pv;
        logic [DW-1:0]    lo_d;
        logic [CW:0]      csum;

        logic             vld_q;
        logic             cy_q;
        logic [DW-1:0]    lo_q;
        logic [RW-CW-1:0] hia_q;
        logic [RW-CW-1:0] hib_q;

        assign csum = {1'b0, pa[CW-1:0]} + {1'b0, pb[CW-1:0]} + {{CW{1'b0}}, pc};

        if (k == 0) begin : g_src
            assign pa   = a;
            assign pb   = b_eff;
            assign pc   = c_eff;
            assign pv   = in_valid;
            assign lo_d = csum[CW-1:0];
        end else begin : g_src
            assign pa   = stg[k-1].hia_q;
            assign pb   = stg[k-1].hib_q;
            assign pc   = stg[k-1].cy_q;
            assign pv   = stg[k-1].vld_q;
            assign lo_d = {csum[CW-1:0], stg[k-1].lo_q};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                lo_q  <= '0;
                hia_q <= '0;
                hib_q <= '0;
            end else if (en) begin
                vld_q <= pv;
                if (pv) begin
                    cy_q  <= csum[CW];
                    lo_q  <= lo_d;
                    hia_q <= pa[RW-1:CW];
                    hib_q <= pb[RW-1:CW];
                end
            end
        end
    end

    // Final rank: top chunk, then flags from the fully assembled word.
    logic [CW-1:0]    fa;
    logic [CW-1:0]    fb;
    logic             fc;
    logic             fv;
    logic [CW:0]      fsum;
    logic [WIDTH-1:0] s_d;
    logic             msb_cin;

    if (STAGES == 1) begin : g_last
        assign fa  = a;
        assign fb  = b_eff;
        assign fc  = c_eff;
        assign fv  = in_valid;
        assign s_d = fsum[CW-1:0];
    end else begin : g_last
        assign fa  = stg[STAGES-2].hia_q;
        assign fb  = stg[STAGES-2].hib_q;
        assign fc  = stg[STAGES-2].cy_q;
        assign fv  = stg[STAGES-2].vld_q;
        assign s_d = {fsum[CW-1:0], stg[STAGES-2].lo_q};
    end

    assign fsum    = {1'b0, fa} + {1'b0, fb} + {{CW{1'b0}}, fc};
    // Carry into the MSB recovered from the sum bit: s = a ^ b ^ cin.
    assign msb_cin = fa[CW-1] ^ fb[CW-1] ^ fsum[CW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (en) begin
            out_valid <= fv;
            if (fv) begin
                s    <= s_d;
                co   <= fsum[CW];
                ovf  <= msb_cin ^ fsum[CW];
                zero <= (s_d == '0);
            end
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed table, random traffic against an arithmetic model, back-pressure and reset sequences.
module tb_pipe_adder;
    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf, zero;
    logic [W-1:0] a, b, s;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf), .zero(zero)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int stalls = 0;
    logic done;

    typedef struct {
        logic [W-1:0] s;
        logic co, ovf, zero;
        int cyc;
        int stl;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    typedef struct {
        logic [W-1:0] a, b;
        logic ci, sub;
        logic [W-1:0] s;
        logic co, ovf, zero;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic m);
        longint ux, uy, sx, sy, cc, u, sg;
        exp_t e;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        cc = longint'(c);
        if (!m) begin
            u    = ux + uy + cc;
            sg   = sx + sy + cc;
            e.co = (u >= 64'sh1_0000_0000);
        end else begin
            u    = ux - uy - cc;
            sg   = sx - sy - cc;
            e.co = (u >= 0);
        end
        e.s    = u[W-1:0];
        e.ovf  = (sg > 64'sh7FFF_FFFF) || (sg < -64'sh8000_0000);
        e.zero = (e.s == '0);
        e.cyc  = 0;
        e.stl  = 0;
        return e;
    endfunction

    // Scoreboard: pushes on accept, checks every cycle the output is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("sb_s", 64'(s), 64'(exp_q[0].s));
                    chk("sb_co", 64'(co), 64'(exp_q[0].co));
                    chk("sb_ovf", 64'(ovf), 64'(exp_q[0].ovf));
                    chk("sb_zero", 64'(zero), 64'(exp_q[0].zero));
                    if (out_ready) begin
                        chk("sb_latency", 64'(cyc - exp_q[0].cyc - (stalls - exp_q[0].stl)), 64'(S));
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (out_valid && !out_ready) stalls++;
            if (in_valid && in_ready) begin
                mon_e     = model(a, b, ci, sub);
                mon_e.cyc = cyc;
                mon_e.stl = stalls;
                exp_q.push_back(mon_e);
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic m);
        int n = 0;
        logic acc = 1'b0;
        a = x; b = y; ci = c; sub = m; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time budget exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;

        tbl[0]  = '{32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        out_ready = 1'b1; done = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_flags", 64'({co, ovf, zero}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, one at a time.
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub);
            wait_out(lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(S));
            chk($sformatf("vec%0d_s", i), 64'(s), 64'(tbl[i].s));
            chk($sformatf("vec%0d_co", i), 64'(co), 64'(tbl[i].co));
            chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(tbl[i].ovf));
            chk($sformatf("vec%0d_zero", i), 64'(zero), 64'(tbl[i].zero));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_one_cycle", i), 64'(out_valid), 64'd0);
        end

        // Random traffic with random gaps and random consumer stalls.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                    send(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        idle(12);
        chk("rand_drain", 64'(exp_q.size()), 64'd0);

        // Back-pressure: 8 back-to-back ops, consumer stalls cycles 6..8.
        fork
            begin
                for (int i = 0; i < 8; i++) send(32'(i), 32'(i * 16), 1'b0, 1'b0);
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    out_ready = !(c >= 6 && c <= 8);
                    @(negedge clk);
                    chk($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'(!(c >= 6 && c <= 8)));
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        idle(10);
        chk("bp_drain", 64'(exp_q.size()), 64'd0);
        chk("bp_last_s", 64'(s), 64'h77);

        // Reset with three ops in flight, before any result emerges.
        send(32'h1, 32'h1, 1'b0, 1'b0);
        send(32'h2, 32'h2, 1'b0, 1'b0);
        send(32'h3, 32'h3, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_s", 64'(s), 64'd0);
        chk("mid_rst_flags", 64'({co, ovf, zero}), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("post_rst_quiet", 64'(seen), 64'd0);
        @(posedge clk); #1;
        send(32'h100, 32'h23, 1'b0, 1'b0);
        wait_out(lat);
        chk("post_rst_latency", 64'(lat), 64'(S));
        chk("post_rst_s", 64'(s), 64'h123);
        @(posedge clk); #1;
        idle(4);
        chk("final_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined N-bit adder/subtractor built from a chunked ripple-carry chain, one chunk per pipeline stage.
- Successor to the single-bit full-adder cell. Adds subtract mode, signed-overflow and zero flags, and a valid/ready handshake.
- Sits between the ID/EX operand registers and the ALU result mux. Serves ADD/ADDU/SUB/SUBU/ADDI/ADDIU and branch compare.

Parameters:
- WIDTH, 32, operand and result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages; each stage computes CW = WIDTH/STAGES bits; 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum/difference.
- co  output  1  carry out of MSB; in sub mode 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  s == 0.

Behaviour:
- Arithmetic:
  - sub=0: {co,s} = a + b + ci.
  - sub=1: {co,s} = a + ~b + ~ci, i.e. a - b - ci.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (s == 0).
  - All results are mod 2^WIDTH.
- Pipeline and carry propagation:
  - Stage k (k = 0..STAGES-1) adds bits [k*CW +: CW] using the carry registered from stage k-1. Stage 0 uses the effective carry-in.
  - Operand chunks for later stages travel with their transaction through skew registers.
  - Completed sum chunks travel through deskew registers, so all chunks of a transaction emerge together.
  - Only the top chunk is computed in the last stage; ovf and zero are also derived there, registered with s.
- Latency and throughput:
  - Latency is exactly STAGES cycles from the in_valid && in_ready accept edge to out_valid.
  - Throughput is 1 result per cycle.
- Handshake (global stall):
  - en = out_ready | ~out_valid; in_ready = en.
  - When en=1, every stage register (data and per-stage valid) advances one step. Stage 0 valid loads in_valid.
  - When en=0, all stage registers hold.
  - Bubbles are not collapsed.
  - Operands are sampled only on an accept edge (in_valid && in_ready).
  - s, co, ovf and zero stay stable while out_valid && !out_ready.
- Simultaneous events:
  - Accept and output-consume in the same cycle is legal and loses no data.
  - in_valid while in_ready=0 is ignored; the source must hold its operands until accepted.
- Reset:
  - On rst_n low, asynchronously: all per-stage valids = 0, out_valid = 0, s = 0, co = 0, ovf = 0, zero = 0.
  - in_ready = 1 during and after reset.
  - Reset mid-operation drops all in-flight transactions. Nothing spurious appears after release.
- STAGES=1 degenerates to a single registered adder with latency 1.

Test Plan:
- ADD carry chain, WIDTH=32/STAGES=4: a=0x00000001, b=0x00000002, ci=0, sub=0 → 4 cycles later s=0x00000003, co=0, ovf=0, zero=0, out_valid=1 for exactly one cycle (out_ready=1).
- Full-width ripple: a=0xFFFFFFFF, b=0x00000001, ci=0 → s=0x00000000, co=1, zero=1, ovf=0. Also a=0xFFFFFFFF, b=0, ci=1 → same result.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, add → s=0x80000000, ovf=1, co=0. a=0x80000000, b=0x00000001, sub=1, ci=0 → s=0x7FFFFFFF, ovf=1, co=1.
- Subtract with borrow: a=5, b=7, sub=1, ci=0 → s=0xFFFFFFFE, co=0, ovf=0. a=7, b=5, sub=1, ci=1 → s=0x00000001, co=1.
- Back-pressure:
  - Stimulus: stream 8 back-to-back ops with i=0..7, a=i, b=0x10*i. Drop out_ready at cycle 6 for 3 cycles.
  - Response: in_ready=0 in exactly those cycles, outputs held stable, all 8 results (s=0x11*i) delivered in order with no loss or duplication.
- Reset mid-flight:
  - Stimulus: issue 3 ops, assert rst_n=0 asynchronously between clock edges before the first result.
  - Response: out_valid=0 and s=0 immediately; after release, no result appears until a new op is issued, and that op returns after 4 cycles.
